// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl_pkg
// Description : Shared types and constants for the counter sequencer/arbiter.
//               Provides the controller state encoding, the counter datapath
//               width, its all-ones saturation value and the default number
//               of requesters.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

  localparam int CNT_WIDTH       = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } ctrl_state_e;

endpackage : counter_ctrl_pkg
`default_nettype wire

// File: rtl/counter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl_if
// Description : Bundles the requester channel, the response channel and the
//               counter control/status signals of counter_ctrl.
//               slave  - the controller side (counter_ctrl)
//               master - requesters, response consumer and counter instance
//               Optional macro COUNTER_CTRL_ABORT_EN adds abort/rsp_aborted.
// Signals     : req_valid/req_ready/req_start/req_steps  job request channel
//               rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_sat  response channel
//               cnt_preload/cnt_preload_val/cnt_enable      counter controls
//               cnt_result/cnt_detect                       counter status
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_ctrl_if import counter_ctrl_pkg::*; #(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = CNT_WIDTH,
  parameter int IDW     = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_start;
  logic [NUM_REQ*WIDTH-1:0] req_steps;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_sat;

  logic                     cnt_preload;
  logic [WIDTH-1:0]         cnt_preload_val;
  logic                     cnt_enable;
  logic [WIDTH-1:0]         cnt_result;
  logic                     cnt_detect;

`ifdef COUNTER_CTRL_ABORT_EN
  logic                     abort;
  logic                     rsp_aborted;

  modport slave (
    input  req_valid, req_start, req_steps, rsp_ready, cnt_result, cnt_detect, abort,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_sat,
           cnt_preload, cnt_preload_val, cnt_enable, rsp_aborted
  );

  modport master (
    output req_valid, req_start, req_steps, rsp_ready, cnt_result, cnt_detect, abort,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_sat,
           cnt_preload, cnt_preload_val, cnt_enable, rsp_aborted
  );
`else
  modport slave (
    input  req_valid, req_start, req_steps, rsp_ready, cnt_result, cnt_detect,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_sat,
           cnt_preload, cnt_preload_val, cnt_enable
  );

  modport master (
    output req_valid, req_start, req_steps, rsp_ready, cnt_result, cnt_detect,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_sat,
           cnt_preload, cnt_preload_val, cnt_enable
  );
`endif

endinterface : counter_ctrl_if
`default_nettype wire

// File: rtl/counter_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first active
//               request at or after 'pointer', wrapping at NUM_REQ. The
//               pointer register belongs to the instantiating block.
// Ports       : req     in  NUM_REQ  request vector
//               pointer in  IDW      highest-priority index this cycle
//               enable  in  1        arbitration allowed
//               grant   out NUM_REQ  one-hot grant (all zero when idle)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  logic w_found;

  // Walk priority offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (enable && !w_found && req[j] &&
            (j == ((int'(pointer) + off) % NUM_REQ))) begin
          grant[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl
// Description : Sequencer/arbiter sharing one saturating counter between
//               NUM_REQ requesters. A granted job preloads the counter with
//               its start value, pulses enable for up to 'steps' cycles
//               (stopping early at all-ones) and returns the final value on
//               a valid/ready response channel.
//               Optional macro COUNTER_CTRL_ABORT_EN adds bus.abort (ends a
//               job early in LOAD/RUN) and bus.rsp_aborted.
// Ports       : clk   in  1  clock
//               rstn  in  1  asynchronous active-low reset
//               bus   slave modport of counter_ctrl_if (request, response
//                     and counter control/status signals)
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl import counter_ctrl_pkg::*; #(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = CNT_WIDTH,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rstn,
  counter_ctrl_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};

  ctrl_state_e        r_state;
  ctrl_state_e        w_next_state;

  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [WIDTH-1:0]   r_start;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_sat;
  logic               r_rsp_aborted;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_any_grant;
  logic               w_arb_en;
  logic [IDW-1:0]     w_gnt_id;
  logic [IDW-1:0]     w_ptr_next;
  logic [WIDTH-1:0]   w_sel_start;
  logic [WIDTH-1:0]   w_sel_steps;
  logic               w_sat_now;
  logic               w_done;
  logic               w_abort;
  logic               w_unused;

`ifdef COUNTER_CTRL_ABORT_EN
  assign w_abort = bus.abort && ((r_state == LOAD) || (r_state == RUN));
`else
  assign w_abort = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration. Gating with rstn keeps req_ready low while reset is held,
  // even though IDLE is already the reset state.
  // ---------------------------------------------------------------------------
  assign w_arb_en = (r_state == IDLE) && rstn;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (bus.req_valid),
    .pointer (r_ptr),
    .enable  (w_arb_en),
    .grant   (w_grant)
  );

  always_comb begin
    w_gnt_id    = '0;
    w_sel_start = '0;
    w_sel_steps = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant[j]) begin
        w_gnt_id    = IDW'(j);
        w_sel_start = bus.req_start[j*WIDTH +: WIDTH];
        w_sel_steps = bus.req_steps[j*WIDTH +: WIDTH];
      end
    end
  end

  assign w_any_grant = |w_grant;
  assign w_ptr_next  = (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : (w_gnt_id + IDW'(1));

  // Completion uses the live counter value rather than cnt_detect: a preload
  // does not clear detect, so it can be stale from a previous job.
  assign w_sat_now = (bus.cnt_result == c_all_ones);
  assign w_done    = (r_rem == '0) || w_sat_now;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_grant)          w_next_state = LOAD;
      LOAD:    w_next_state = w_abort ? RESP : RUN;
      RUN:     if (w_abort || w_done)    w_next_state = RESP;
      RESP:    if (bus.rsp_ready)        w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Preload is only driven in LOAD and enable only in RUN, so
  // the two can never overlap.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready       = '0;
    bus.cnt_preload     = 1'b0;
    bus.cnt_preload_val = '0;
    bus.cnt_enable      = 1'b0;
    case (r_state)
      IDLE: bus.req_ready = w_grant;
      LOAD: begin
        if (!w_abort) begin
          bus.cnt_preload     = 1'b1;
          bus.cnt_preload_val = r_start;
        end
      end
      RUN:  bus.cnt_enable = !w_done && !w_abort;
      default: ;
    endcase
  end

  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_sat    = r_rsp_sat;

`ifdef COUNTER_CTRL_ABORT_EN
  assign bus.rsp_aborted = r_rsp_aborted;
  assign w_unused        = bus.cnt_detect;
`else
  assign w_unused        = bus.cnt_detect ^ r_rsp_aborted;
`endif

  // ---------------------------------------------------------------------------
  // Job datapath: captured request, remaining steps and response registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr         <= '0;
      r_id          <= '0;
      r_start       <= '0;
      r_rem         <= '0;
      r_rsp_result  <= '0;
      r_rsp_sat     <= 1'b0;
      r_rsp_aborted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_grant) begin
            r_id    <= w_gnt_id;
            r_start <= w_sel_start;
            r_rem   <= w_sel_steps;
            r_ptr   <= w_ptr_next;
          end
        end
        LOAD: begin
          if (w_abort) begin
            r_rsp_result  <= bus.cnt_result;
            r_rsp_sat     <= w_sat_now;
            r_rsp_aborted <= 1'b1;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_rsp_result  <= bus.cnt_result;
            r_rsp_sat     <= w_sat_now;
            r_rsp_aborted <= 1'b1;
          end else if (w_done) begin
            r_rsp_result  <= bus.cnt_result;
            r_rsp_sat     <= w_sat_now;
            r_rsp_aborted <= 1'b0;
          end else begin
            r_rem <= r_rem - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : counter_ctrl
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ctrl
// Description : Directed self-checking bench for counter_ctrl. Models the
//               4-bit saturating counter and drives requesters/consumer.
//               Define COUNTER_CTRL_ABORT_EN to also exercise abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

  localparam int NR = 4;
  localparam int W  = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int n_en   = 0;
  int n_pre  = 0;
  int n_both = 0;

  int rr_start [4] = '{1, 3, 5, 9};

  counter_ctrl_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  counter_ctrl #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Saturating counter model
  always @(posedge clk or negedge rstn) begin
    if (!rstn)                                        bus.cnt_result <= '0;
    else if (bus.cnt_preload)                         bus.cnt_result <= bus.cnt_preload_val;
    else if (bus.cnt_enable && bus.cnt_result != 4'hF) bus.cnt_result <= bus.cnt_result + 4'd1;
  end
  assign bus.cnt_detect = (bus.cnt_result == 4'hF);

  // Mid-cycle activity monitor
  always @(negedge clk) begin
    if (bus.cnt_enable)                    n_en++;
    if (bus.cnt_preload)                   n_pre++;
    if (bus.cnt_enable && bus.cnt_preload) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int who, input logic [3:0] st, input logic [3:0] sp);
    bus.req_start[who*W +: W] = st;
    bus.req_steps[who*W +: W] = sp;
    bus.req_valid[who]        = 1'b1;
  endtask

  task automatic wait_grant(output int g, output int waited);
    waited = 0;
    g      = -1;
    while (bus.req_ready == '0 && waited < 50) begin
      tick();
      waited++;
    end
    check("grant_wait", (waited < 50), 1);
    for (int j = 0; j < NR; j++) if (bus.req_ready[j]) g = j;
  endtask

  task automatic wait_rsp();
    int k = 0;
    while (!bus.rsp_valid && k < 50) begin
      tick();
      k++;
    end
    check("rsp_wait", (k < 50), 1);
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_job(input string tag, input int who, input logic [3:0] st,
                        input logic [3:0] sp, input int e_res, input int e_sat,
                        input int e_en, input int e_lat);
    int g, wt, t0;
    set_req(who, st, sp);
    #1;
    wait_grant(g, wt);
    check({tag, ".gnt"}, bus.req_ready, 32'd1 << who);
    t0    = cyc;
    n_en  = 0;
    n_pre = 0;
    tick();
    bus.req_valid[who] = 1'b0;
    wait_rsp();
    check({tag, ".lat"}, cyc - t0, e_lat);
    check({tag, ".id"},  bus.rsp_id, who);
    check({tag, ".res"}, bus.rsp_result, e_res);
    check({tag, ".sat"}, bus.rsp_sat, e_sat);
    check({tag, ".en"},  n_en, e_en);
    check({tag, ".pre"}, n_pre, 1);
`ifdef COUNTER_CTRL_ABORT_EN
    check({tag, ".abt"}, bus.rsp_aborted, 0);
`endif
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, wt;
    bus.req_valid = '0;
    bus.req_start = '0;
    bus.req_steps = '0;
    bus.rsp_ready = 1'b0;
`ifdef COUNTER_CTRL_ABORT_EN
    bus.abort     = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    check("rst.ready",   bus.req_ready, 0);
    check("rst.valid",   bus.rsp_valid, 0);
    check("rst.id",      bus.rsp_id, 0);
    check("rst.res",     bus.rsp_result, 0);
    check("rst.sat",     bus.rsp_sat, 0);
    check("rst.pre",     bus.cnt_preload, 0);
    check("rst.preval",  bus.cnt_preload_val, 0);
    check("rst.en",      bus.cnt_enable, 0);
    rstn = 1'b1;
    tick();

    // Single job, saturation, steps=0 cases (pointer walks 0,1,2,3)
    do_job("single", 0, 4'd2,  4'd3, 5,  0, 3, 6);
    do_job("sat",    1, 4'd13, 4'd9, 15, 1, 2, 5);
    do_job("full0",  2, 4'd15, 4'd0, 15, 1, 0, 3);
    do_job("zero",   3, 4'd7,  4'd0, 7,  0, 0, 3);

    // Round robin with all requesters held active
    for (int i = 0; i < NR; i++) set_req(i, 4'(rr_start[i]), 4'd1);
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, wt);
      check("rr.bubble", wt, 0);
      check("rr.order", g, k % 4);
      tick();
      if (k == 4) bus.req_valid = '0;
      wait_rsp();
      check("rr.id",  bus.rsp_id, k % 4);
      check("rr.res", bus.rsp_result, rr_start[k % 4] + 1);
      handshake();
    end

    // Backpressure: response held, pending request must wait
    set_req(1, 4'd4, 4'd2);
    #1;
    wait_grant(g, wt);
    check("bp.gnt", g, 1);
    tick();
    bus.req_valid[1] = 1'b0;
    wait_rsp();
    set_req(2, 4'd0, 4'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.valid",   bus.rsp_valid, 1);
      check("bp.res",     bus.rsp_result, 6);
      check("bp.id",      bus.rsp_id, 1);
      check("bp.nogrant", bus.req_ready, 0);
      check("bp.noen",    bus.cnt_enable, 0);
      tick();
    end
    handshake();
    check("bp.regrant", bus.req_ready, 4);
    tick();
    bus.req_valid[2] = 1'b0;
    wait_rsp();
    check("bp2.res", bus.rsp_result, 1);
    check("bp2.id",  bus.rsp_id, 2);
    handshake();

    // Reset during RUN after two enable cycles
    set_req(3, 4'd0, 4'd8);
    #1;
    wait_grant(g, wt);
    check("mr.gnt", g, 3);
    n_en = 0;
    repeat (4) tick();
    check("mr.en_cnt", n_en, 2);
    check("mr.en_on",  bus.cnt_enable, 1);
    rstn = 1'b0;
    #1;
    check("mr.ready", bus.req_ready, 0);
    check("mr.en",    bus.cnt_enable, 0);
    check("mr.pre",   bus.cnt_preload, 0);
    check("mr.valid", bus.rsp_valid, 0);
    check("mr.res",   bus.rsp_result, 0);
    check("mr.id",    bus.rsp_id, 0);
    tick();
    rstn = 1'b1;
    #1;
    check("mr.regrant", bus.req_ready, 8);
    tick();
    bus.req_valid[3] = 1'b0;
    wait_rsp();
    check("mr.res2", bus.rsp_result, 8);
    check("mr.id2",  bus.rsp_id, 3);
    handshake();

`ifdef COUNTER_CTRL_ABORT_EN
    // Abort in the second RUN cycle, then a normal job
    set_req(0, 4'd0, 4'd10);
    #1;
    wait_grant(g, wt);
    check("ab.gnt", g, 0);
    repeat (3) tick();
    bus.abort = 1'b1;
    #1;
    check("ab.noen",  bus.cnt_enable, 0);
    check("ab.nopre", bus.cnt_preload, 0);
    tick();
    bus.abort = 1'b0;
    check("ab.valid", bus.rsp_valid, 1);
    check("ab.flag",  bus.rsp_aborted, 1);
    check("ab.res",   bus.rsp_result, 1);
    handshake();
    do_job("ab.next", 1, 4'd3, 4'd2, 5, 0, 2, 5);
`endif

    check("overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_counter_ctrl
`default_nettype wire
